// File: rtl/dq_rdwr_bus_scheduler_pkg.sv
// Shared definitions for the DQ-bus read/write scheduler: default timing,
// bank-group type and the bus-direction FSM encoding.
package dq_rdwr_bus_scheduler_pkg;

    localparam int unsigned DQ_BG_W       = 2;
    localparam int unsigned DQ_T_CCD_S    = 4;
    localparam int unsigned DQ_T_CCD_L    = 6;
    localparam int unsigned DQ_T_WTR_S    = 12;
    localparam int unsigned DQ_T_WTR_L    = 16;
    localparam int unsigned DQ_T_RTW      = 8;
    localparam int unsigned DQ_STARVE_MAX = 16;

    typedef logic [DQ_BG_W-1:0] bg_t;

    typedef enum logic [1:0] {
        RD    = 2'd0,
        WR    = 2'd1,
        RD2WR = 2'd2,
        WR2RD = 2'd3
    } dq_sched_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Write mode covers the write state and the turnaround heading into it.
    function automatic logic is_write_dir(input dq_sched_state_e s);
        return (s == WR) || (s == RD2WR);
    endfunction

endpackage

// File: rtl/dq_gap_timer.sv
// Tracks cycles since the last granted CAS plus its direction and bank group,
// and reports whether a read or write CAS may issue now.
module dq_gap_timer
    import dq_rdwr_bus_scheduler_pkg::*;
#(
    parameter int unsigned BG_W    = DQ_BG_W,
    parameter int unsigned T_CCD_S = DQ_T_CCD_S,
    parameter int unsigned T_CCD_L = DQ_T_CCD_L,
    parameter int unsigned T_WTR_S = DQ_T_WTR_S,
    parameter int unsigned T_WTR_L = DQ_T_WTR_L,
    parameter int unsigned T_RTW   = DQ_T_RTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_gnt,
    input  logic            wr_gnt,
    input  logic [BG_W-1:0] rd_bg,
    input  logic [BG_W-1:0] wr_bg,
    output logic            rd_eligible,
    output logic            wr_eligible,
    output logic [BG_W-1:0] last_bg
);

    localparam int unsigned GAP_MAX = max_u(max_u(max_u(T_CCD_S, T_CCD_L),
                                                  max_u(T_WTR_S, T_WTR_L)), T_RTW);
    localparam int unsigned EL_W    = $clog2(GAP_MAX + 1);
    localparam logic [EL_W-1:0] EL_SAT = EL_W'(GAP_MAX);

    logic [EL_W-1:0] elapsed;
    logic [EL_W-1:0] rd_gap;
    logic [EL_W-1:0] wr_gap;
    logic            last_dir;
    logic            last_valid;

    // Reset parks elapsed at saturation so stale history can never block a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            elapsed    <= EL_SAT;
            last_dir   <= 1'b0;
            last_bg    <= '0;
            last_valid <= 1'b0;
        end else if (rd_gnt || wr_gnt) begin
            elapsed    <= EL_W'(1);
            last_dir   <= wr_gnt;
            last_bg    <= wr_gnt ? wr_bg : rd_bg;
            last_valid <= 1'b1;
        end else if (elapsed != EL_SAT) begin
            elapsed    <= elapsed + EL_W'(1);
        end
    end

    // Required gap depends on the last direction and on the current request's bank group.
    always_comb begin
        rd_gap = EL_W'(T_CCD_S);
        wr_gap = EL_W'(T_RTW);
        if (last_dir) begin
            rd_gap = (rd_bg == last_bg) ? EL_W'(T_WTR_L) : EL_W'(T_WTR_S);
            wr_gap = (wr_bg == last_bg) ? EL_W'(T_CCD_L) : EL_W'(T_CCD_S);
        end else begin
            rd_gap = (rd_bg == last_bg) ? EL_W'(T_CCD_L) : EL_W'(T_CCD_S);
        end
        rd_eligible = !last_valid || (elapsed >= rd_gap);
        wr_eligible = !last_valid || (elapsed >= wr_gap);
    end

endmodule

// File: rtl/dq_rdwr_bus_scheduler.sv
// Per-channel DQ-bus scheduler: picks at most one read or write CAS per cycle,
// honouring CAS spacing, bus turnaround, write drain and starvation limits.
module dq_rdwr_bus_scheduler
    import dq_rdwr_bus_scheduler_pkg::*;
#(
    parameter int unsigned BG_W       = DQ_BG_W,
    parameter int unsigned T_CCD_S    = DQ_T_CCD_S,
    parameter int unsigned T_CCD_L    = DQ_T_CCD_L,
    parameter int unsigned T_WTR_S    = DQ_T_WTR_S,
    parameter int unsigned T_WTR_L    = DQ_T_WTR_L,
    parameter int unsigned T_RTW      = DQ_T_RTW,
    parameter int unsigned STARVE_MAX = DQ_STARVE_MAX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmdReady,
    input  logic            rdReq,
    input  logic [BG_W-1:0] rdBG,
    input  logic            wrReq,
    input  logic [BG_W-1:0] wrBG,
    input  logic            wrDrain,
    output logic            rdGnt,
    output logic            wrGnt,
    output logic            busDir,
    output logic [BG_W-1:0] lastBG
);

    localparam int unsigned ST_W = $clog2(STARVE_MAX + 1);
    localparam logic [ST_W-1:0] ST_SAT = ST_W'(STARVE_MAX);

    dq_sched_state_e state;
    dq_sched_state_e next_state;

    logic [ST_W-1:0] rd_starve;
    logic [ST_W-1:0] wr_starve;
    logic            rd_starved;
    logic            wr_starved;
    logic            rd_eligible;
    logic            wr_eligible;
    logic            rd_phase;
    logic            wr_phase;

    dq_gap_timer #(
        .BG_W    (BG_W),
        .T_CCD_S (T_CCD_S),
        .T_CCD_L (T_CCD_L),
        .T_WTR_S (T_WTR_S),
        .T_WTR_L (T_WTR_L),
        .T_RTW   (T_RTW)
    ) u_gap_timer (
        .clk         (clk),
        .rst         (rst),
        .rd_gnt      (rdGnt),
        .wr_gnt      (wrGnt),
        .rd_bg       (rdBG),
        .wr_bg       (wrBG),
        .rd_eligible (rd_eligible),
        .wr_eligible (wr_eligible),
        .last_bg     (lastBG)
    );

    assign rd_starved = rdReq && (rd_starve >= ST_SAT);
    assign wr_starved = wrReq && (wr_starve >= ST_SAT);
    assign rd_phase   = (state == RD) || (state == WR2RD);
    assign wr_phase   = (state == WR) || (state == RD2WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RD;
        end else begin
            state <= next_state;
        end
    end

    // Grants and direction choice; read starvation outranks drain, drain outranks staying put.
    always_comb begin
        next_state = state;
        rdGnt      = 1'b0;
        wrGnt      = 1'b0;
        if (rst) begin
            next_state = RD;
        end else begin
            rdGnt = rdReq && cmdReady && rd_eligible && rd_phase;
            wrGnt = wrReq && cmdReady && wr_eligible && wr_phase;
            unique case (state)
                RD: begin
                    if (!rd_starved && wrReq && (!rdReq || wrDrain || wr_starved)) begin
                        next_state = RD2WR;
                    end
                end
                RD2WR: begin
                    if (wrGnt) begin
                        next_state = WR;
                    end else if (!wrReq) begin
                        next_state = RD;
                    end
                end
                WR: begin
                    if (rdReq && (rd_starved || (!wrReq && !wrDrain))) begin
                        next_state = WR2RD;
                    end
                end
                WR2RD: begin
                    if (rdGnt) begin
                        next_state = RD;
                    end else if (!rdReq) begin
                        next_state = WR;
                    end
                end
                default: next_state = RD;
            endcase
        end
        busDir = is_write_dir(next_state);
    end

    // Wait counters: reset by their own grant or an idle request, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_starve <= '0;
            wr_starve <= '0;
        end else begin
            if (!rdReq || rdGnt) begin
                rd_starve <= '0;
            end else if (rd_starve != ST_SAT) begin
                rd_starve <= rd_starve + ST_W'(1);
            end
            if (!wrReq || wrGnt) begin
                wr_starve <= '0;
            end else if (wr_starve != ST_SAT) begin
                wr_starve <= wr_starve + ST_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dq_rdwr_bus_scheduler.sv
// Cycle-exact bench for dq_rdwr_bus_scheduler: per-cycle vectors whose expected
// outputs are queued on drive and compared mid-cycle by a monitor.
module tb_dq_rdwr_bus_scheduler;

    typedef struct {
        string      name;
        logic       rst;
        logic       rdy;
        logic       rr;
        logic [1:0] rbg;
        logic       wr;
        logic [1:0] wbg;
        logic       dr;
        logic       e_rd;
        logic       e_wr;
        logic       e_dir;
        logic [1:0] e_bg;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       cmdReady;
    logic       rdReq;
    logic [1:0] rdBG;
    logic       wrReq;
    logic [1:0] wrBG;
    logic       wrDrain;
    logic       rdGnt;
    logic       wrGnt;
    logic       busDir;
    logic [1:0] lastBG;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    dq_rdwr_bus_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .cmdReady (cmdReady),
        .rdReq    (rdReq),
        .rdBG     (rdBG),
        .wrReq    (wrReq),
        .wrBG     (wrBG),
        .wrDrain  (wrDrain),
        .rdGnt    (rdGnt),
        .wrGnt    (wrGnt),
        .busDir   (busDir),
        .lastBG   (lastBG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic r, input logic rdy,
                                input logic rr, input logic [1:0] rbg,
                                input logic wr, input logic [1:0] wbg, input logic dr,
                                input logic e_rd, input logic e_wr, input logic e_dir,
                                input logic [1:0] e_bg);
        vec_t v;
        v.name = n;  v.rst = r;     v.rdy = rdy;     v.rr = rr;     v.rbg = rbg;
        v.wr = wr;   v.wbg = wbg;   v.dr = dr;       v.e_rd = e_rd; v.e_wr = e_wr;
        v.e_dir = e_dir;  v.e_bg = e_bg;
        return v;
    endfunction

    task automatic add(input vec_t v, input int reps);
        for (int i = 0; i < reps; i++) tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst      = v.rst;
        cmdReady = v.rdy;
        rdReq    = v.rr;
        rdBG     = v.rbg;
        wrReq    = v.wr;
        wrBG     = v.wbg;
        wrDrain  = v.dr;
        exp_q.push_back(v);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: one queued expectation per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        vec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({rdGnt, wrGnt, busDir, lastBG} !== {e.e_rd, e.e_wr, e.e_dir, e.e_bg}) begin
                errors++;
                $display("FAIL %s @%0t: got rdGnt=%0b wrGnt=%0b busDir=%0b lastBG=%0d, expected rdGnt=%0b wrGnt=%0b busDir=%0b lastBG=%0d",
                         e.name, $time, rdGnt, wrGnt, busDir, lastBG,
                         e.e_rd, e.e_wr, e.e_dir, e.e_bg);
            end
        end
    end

    initial begin
        logic       e_rd;
        logic       e_wr;
        logic       e_dir;
        logic [1:0] e_bg;

        rst = 1'b1; cmdReady = 1'b0; rdReq = 1'b0; rdBG = 2'd0;
        wrReq = 1'b0; wrBG = 2'd0; wrDrain = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset-state values of all outputs.
        checks++;
        if (rdGnt !== 1'b0 || wrGnt !== 1'b0 || busDir !== 1'b0 || lastBG !== 2'd0) begin
            errors++;
            $display("FAIL reset_state @%0t: got rdGnt=%0b wrGnt=%0b busDir=%0b lastBG=%0d",
                     $time, rdGnt, wrGnt, busDir, lastBG);
        end

        // name, rst, rdy, rr, rbg, wr, wbg, dr | rdGnt, wrGnt, busDir, lastBG
        add(mk("reset_hold",   1'b1,1'b1,1'b1,2'd0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd0), 3);
        add(mk("first_rd",     1'b0,1'b1,1'b1,2'd0,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,2'd0), 1);
        add(mk("ccd_l_gap",    1'b0,1'b1,1'b1,2'd0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd0), 5);
        add(mk("ccd_l_rd",     1'b0,1'b1,1'b1,2'd0,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,2'd0), 1);
        add(mk("ccd_l_gap2",   1'b0,1'b1,1'b1,2'd0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd0), 5);
        add(mk("ccd_l_rd2",    1'b0,1'b1,1'b1,2'd0,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,2'd0), 1);
        add(mk("ccd_s_gap_b1", 1'b0,1'b1,1'b1,2'd1,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd0), 3);
        add(mk("ccd_s_rd_b1",  1'b0,1'b1,1'b1,2'd1,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,2'd0), 1);
        add(mk("ccd_s_gap_b0", 1'b0,1'b1,1'b1,2'd0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd1), 3);
        add(mk("ccd_s_rd_b0",  1'b0,1'b1,1'b1,2'd0,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,2'd1), 1);
        add(mk("ccd_s_gap_b1", 1'b0,1'b1,1'b1,2'd1,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd0), 3);
        add(mk("ccd_s_rd_b1",  1'b0,1'b1,1'b1,2'd1,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,2'd0), 1);
        add(mk("rtw_gap",      1'b0,1'b1,1'b0,2'd0,1'b1,2'd0,1'b0, 1'b0,1'b0,1'b1,2'd1), 7);
        add(mk("rtw_wr",       1'b0,1'b1,1'b0,2'd0,1'b1,2'd0,1'b0, 1'b0,1'b1,1'b1,2'd1), 1);
        add(mk("wr_idle",      1'b0,1'b1,1'b0,2'd0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b1,2'd0), 1);
        add(mk("wr_ccd_s_gap", 1'b0,1'b1,1'b0,2'd0,1'b1,2'd2,1'b0, 1'b0,1'b0,1'b1,2'd0), 2);
        add(mk("wr_ccd_s_wr",  1'b0,1'b1,1'b0,2'd0,1'b1,2'd2,1'b0, 1'b0,1'b1,1'b1,2'd0), 1);
        add(mk("wtr_l_gap",    1'b0,1'b1,1'b1,2'd2,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd2), 15);
        add(mk("wtr_l_rd",     1'b0,1'b1,1'b1,2'd2,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,2'd2), 1);
        add(mk("rtw2_gap",     1'b0,1'b1,1'b0,2'd0,1'b1,2'd2,1'b0, 1'b0,1'b0,1'b1,2'd2), 7);
        add(mk("rtw2_wr",      1'b0,1'b1,1'b0,2'd0,1'b1,2'd2,1'b0, 1'b0,1'b1,1'b1,2'd2), 1);
        add(mk("wtr_s_gap",    1'b0,1'b1,1'b1,2'd3,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd2), 11);
        add(mk("wtr_s_rd",     1'b0,1'b1,1'b1,2'd3,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,2'd2), 1);
        add(mk("rd_idle",      1'b0,1'b1,1'b0,2'd0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd3), 1);

        foreach (tbl[i]) drive(tbl[i]);

        // Both held, no drain: write starvation forces the switch, then read starvation returns.
        for (int k = 0; k <= 42; k++) begin
            e_rd  = (k == 4) || (k == 10) || (k == 16) || (k == 42);
            e_wr  = (k == 24) || (k == 30);
            e_dir = (k >= 16) && (k < 33);
            e_bg  = (k <= 24) ? 2'd3 : 2'd0;
            drive(mk("starve_switch", 1'b0,1'b1,1'b1,2'd3,1'b1,2'd0,1'b0, e_rd,e_wr,e_dir,e_bg));
        end
        drive(mk("starve_idle", 1'b0,1'b1,1'b0,2'd0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,2'd3));

        // Drain raised mid-gap: switch next cycle, write lands at last read + T_RTW.
        for (int k = 0; k <= 18; k++) begin
            e_rd  = (k == 4) || (k == 10);
            e_wr  = (k == 18);
            e_dir = (k >= 12);
            drive(mk("drain_switch", 1'b0,1'b1,1'b1,2'd3,1'b1,2'd1,(k >= 12),
                     e_rd,e_wr,e_dir,2'd3));
        end
        drive(mk("drain_idle", 1'b0,1'b1,1'b0,2'd0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b1,2'd1));

        // cmdReady low across the eligible cycle delays the write.
        for (int k = 0; k <= 7; k++) begin
            drive(mk("defer_wr", 1'b0,(k >= 7),1'b0,2'd0,1'b1,2'd1,1'b0,
                     1'b0,(k == 7),1'b1,2'd1));
        end
        for (int k = 8; k <= 19; k++) begin
            drive(mk("wtr_s_turn", 1'b0,1'b1,1'b1,2'd0,1'b0,2'd0,1'b0,
                     (k == 19),1'b0,1'b0,2'd1));
        end
        drive(mk("withdraw_enter", 1'b0,1'b1,1'b1,2'd0,1'b1,2'd1,1'b1, 1'b0,1'b0,1'b1,2'd0));
        drive(mk("withdraw_hold",  1'b0,1'b1,1'b1,2'd0,1'b1,2'd1,1'b1, 1'b0,1'b0,1'b1,2'd0));
        for (int k = 22; k <= 27; k++) begin
            drive(mk("withdraw_resume", 1'b0,!((k == 25) || (k == 26)),1'b1,2'd0,1'b0,2'd0,1'b0,
                     (k == 27),1'b0,1'b0,2'd0));
        end

        // Reset in the middle of a read-to-write turnaround drops the RTW constraint.
        drive(mk("rst_turn_pre", 1'b0,1'b1,1'b0,2'd0,1'b1,2'd2,1'b0, 1'b0,1'b0,1'b1,2'd0));
        drive(mk("rst_mid_turn", 1'b1,1'b1,1'b0,2'd0,1'b1,2'd2,1'b0, 1'b0,1'b0,1'b0,2'd0));
        drive(mk("rst_mid_turn", 1'b1,1'b1,1'b0,2'd0,1'b1,2'd2,1'b0, 1'b0,1'b0,1'b0,2'd0));
        drive(mk("post_rst_rd",  1'b0,1'b1,1'b0,2'd0,1'b1,2'd2,1'b0, 1'b0,1'b0,1'b1,2'd0));
        drive(mk("post_rst_wr",  1'b0,1'b1,1'b0,2'd0,1'b1,2'd2,1'b0, 1'b0,1'b1,1'b1,2'd0));
        drive(mk("post_rst_idle",1'b0,1'b1,1'b0,2'd0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b1,2'd2));

        if (errors != 0 || checks < 12) begin
            $display("FAIL: %0d checks, %0d errors", checks, errors);
        end else begin
            $display("PASS: %0d checks, %0d errors", checks, errors);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dq_rdwr_bus_scheduler.md
Name: dq_rdwr_bus_scheduler

Overview:
Per-channel DQ-bus scheduler. It arbitrates one CAS per cycle between a read requester and a write requester. It enforces CAS-to-CAS spacing (tCCD_S/tCCD_L), write-to-read turnaround (tWTR_S/L) and read-to-write turnaround (tRTW), all measured from the last granted CAS. It sits between the channel read/write queues and the command bus, and is the single authority on when DQ may carry the next burst.

Parameters:
BG_W, 2, bank-group field width
T_CCD_S, 4, min cycles between same-direction CAS, different bank group
T_CCD_L, 6, min cycles between same-direction CAS, same bank group
T_WTR_S, 12, min cycles from write CAS to read CAS, different bank group
T_WTR_L, 16, min cycles from write CAS to read CAS, same bank group
T_RTW, 8, min cycles from read CAS to write CAS, any bank group
STARVE_MAX, 16, wait cycles after which the non-current direction forces a switch

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cmdReady  in  1  command bus can accept a CAS this cycle
rdReq  in  1  read CAS pending; held until rdGnt
rdBG  in  BG_W  bank group of pending read
wrReq  in  1  write CAS pending; held until wrGnt
wrBG  in  BG_W  bank group of pending write
wrDrain  in  1  write buffer above high watermark
rdGnt  out  1  read CAS issued this cycle (one-cycle pulse)
wrGnt  out  1  write CAS issued this cycle (one-cycle pulse)
busDir  out  1  0 = read mode (RD, WR2RD), 1 = write mode (WR, RD2WR)
lastBG  out  BG_W  bank group of last granted CAS

Behaviour:
- Handshake:
  - A CAS is issued in a cycle where req and gnt are both high.
  - Grants are combinational from registered state and current inputs; zero added latency.
  - rdGnt and wrGnt are never high together.
  - Grants are forced 0 while rst is high.
- Gap timer:
  - `elapsed` counts cycles since the last grant: grant at t0 gives elapsed = k at t0+k.
  - It saturates at max(all gaps); width is $clog2(max gap + 1).
  - Registers lastDir, lastBG and lastValid are updated on every grant.
- Eligibility (when lastValid = 1):
  - Read after read: elapsed >= (rdBG == lastBG ? T_CCD_L : T_CCD_S).
  - Write after write: same rule using wrBG.
  - Read after write: elapsed >= (rdBG == lastBG ? T_WTR_L : T_WTR_S).
  - Write after read: elapsed >= T_RTW.
  - When lastValid = 0, everything is eligible.
- A grant requires eligibility AND cmdReady AND the FSM permitting that direction.
- When cmdReady = 0, the grant is deferred. elapsed keeps counting and no state changes are caused by the deferral.
- FSM states: RD, WR, RD2WR, WR2RD. Reset state is RD.
  - RD: only reads may be granted.
    - Go to RD2WR when wrReq is high and any of: rdReq low, wrDrain high, or wrStarve >= STARVE_MAX.
    - Read starvation check has priority: if rdStarve >= STARVE_MAX, stay in RD.
  - RD2WR: no reads granted; wrGnt is given once the write is eligible.
    - On wrGnt go to WR.
    - If wrReq drops before grant, go back to RD.
  - WR: mirror of RD. Go to WR2RD when rdReq is high and any of: wrReq low, or rdStarve >= STARVE_MAX.
    - While wrDrain is high and rdStarve < STARVE_MAX, stay in WR.
  - WR2RD: mirror of RD2WR.
- Starvation counters:
  - rdStarve increments each cycle rdReq is high and rdGnt is low; wrStarve likewise for writes.
  - Each clears on its own grant or when its req is low, and saturates at STARVE_MAX.
- Priority order when both directions qualify: read starvation > wrDrain > current direction.
- Reset values:
  - Outputs: rdGnt = 0, wrGnt = 0, busDir = 0, lastBG = 0.
  - Internal: elapsed = saturated, lastValid = 0, both starvation counters = 0.
- Reset asserted mid-gap or mid-turnaround discards all timing history. The first grant after reset is unconstrained.
- A BG change on a held request is allowed; eligibility is evaluated on the current BG each cycle.

Decomposition:
- Shared package (MemoryController_Definitions) gains:
  - constants T_RTW, T_WTR_S, T_WTR_L next to the existing tCCDS/tCCDL;
  - typedef enum dq_sched_state_e {RD, WR, RD2WR, WR2RD};
  - typedef logic [BG_W-1:0] bg_t.
- One sub-module, dq_gap_timer: holds elapsed, lastDir, lastBG and lastValid, and outputs rdEligible/wrEligible given rdBG/wrBG.
- The top level holds the FSM, starvation counters and grant logic.

Test Plan:
1. Reset: rst high for 3 cycles with rdReq = 1, cmdReady = 1 -> no grant during reset; rdGnt = 1 on the first cycle after release.
2. Read stream: rdReq held with rdBG = 0 -> grants at t, t+6, t+12. With rdBG alternating 0/1 -> grants every 4 cycles.
3. Read-to-write: read granted at t0, then only wrReq is high -> FSM moves to RD2WR, busDir = 1 from t0+1, wrGnt at t0+8, then state WR.
4. Write-to-read: write granted at t0 with BG 2 -> rdGnt at t0+16 for rdBG = 2, or at t0+12 for rdBG = 3.
5. Starvation and drain: both reqs held in RD with no drain -> reads continue until wrStarve reaches 16, then switch. Repeat with wrDrain = 1 -> switch on the next cycle; wrGnt at last read + 8.
6. Deferral and withdrawal: cmdReady = 0 on the eligible cycle -> grant slips to the first cycle cmdReady = 1. wrReq dropped while in RD2WR -> state returns to RD and reads resume on CCD timing.
